// File: rtl/rggen_bit_field_cell_pkg.sv
// Shared types for register bit fields: bus direction, response status,
// field access modes and hardware-control polarities.
package rggen_bit_field_cell_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    RGGEN_SET_MODE   = 1'b0,
    RGGEN_CLEAR_MODE = 1'b1
  } rggen_rwsc_mode;

  typedef enum logic {
    RGGEN_LOCK_MODE   = 1'b0,
    RGGEN_ENABLE_MODE = 1'b1
  } rggen_rwle_mode;

  typedef enum logic [2:0] {
    RGGEN_FIELD_RW   = 3'd0,
    RGGEN_FIELD_RO   = 3'd1,
    RGGEN_FIELD_RWSC = 3'd2,
    RGGEN_FIELD_RWLE = 3'd3,
    RGGEN_FIELD_W1C  = 3'd4,
    RGGEN_FIELD_W1S  = 3'd5
  } rggen_field_mode;

  // In LOCK_MODE the control input locks the field; in ENABLE_MODE it unlocks it.
  function automatic logic write_locked(rggen_rwle_mode mode, logic control);
    return (mode == RGGEN_LOCK_MODE) ? control : !control;
  endfunction

endpackage

// File: rtl/rggen_bit_field_next_value.sv
// Per-bit next-state function of a register field. Software effects are
// applied first, hardware events last, so a same-cycle hw event wins.
module rggen_bit_field_next_value
  import rggen_bit_field_cell_pkg::*;
#(
  parameter int             WIDTH     = 32,
  parameter rggen_field_mode MODE      = RGGEN_FIELD_RW,
  parameter rggen_rwsc_mode  RWSC_MODE = RGGEN_SET_MODE,
  parameter rggen_rwle_mode  RWLE_MODE = RGGEN_LOCK_MODE
) (
  input  logic [WIDTH-1:0] value,
  input  logic             write,
  input  logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] write_mask,
  input  logic [WIDTH-1:0] hw_event,
  input  logic             hw_control,
  output logic [WIDTH-1:0] next_value
);

  logic [WIDTH-1:0] sw_bits;
  logic [WIDTH-1:0] rw_value;

  assign sw_bits  = write ? write_mask : '0;
  assign rw_value = (value & ~sw_bits) | (write_data & sw_bits);

  always_comb begin
    // NOTE: default first so every path assigns next_value and no latch is inferred.
    next_value = value;
    case (MODE)
      RGGEN_FIELD_RW:   next_value = rw_value;
      RGGEN_FIELD_RO:   next_value = value;
      RGGEN_FIELD_RWSC: begin
        if (RWSC_MODE == RGGEN_SET_MODE) next_value = rw_value | hw_event;
        else                             next_value = rw_value & ~hw_event;
      end
      RGGEN_FIELD_RWLE: begin
        if (!write_locked(RWLE_MODE, hw_control)) next_value = rw_value;
      end
      RGGEN_FIELD_W1C:  next_value = (value & ~(write_data & sw_bits)) | hw_event;
      RGGEN_FIELD_W1S:  next_value = (value | (write_data & sw_bits)) & ~hw_event;
      default:          next_value = value;
    endcase
  end

endmodule

// File: rtl/rggen_bit_field_cell.sv
// Single register field with a valid/ready command port and a held response.
// One access is in flight at a time; the field flop is updated on accept.
module rggen_bit_field_cell
  import rggen_bit_field_cell_pkg::*;
#(
  parameter int              WIDTH         = 32,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter rggen_field_mode  MODE          = RGGEN_FIELD_RW,
  parameter rggen_rwsc_mode   RWSC_MODE     = RGGEN_SET_MODE,
  parameter rggen_rwle_mode   RWLE_MODE     = RGGEN_LOCK_MODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_command_valid,
  output logic             o_command_ready,
  input  rggen_direction   i_command_direction,
  input  logic [WIDTH-1:0] i_command_write_data,
  input  logic [WIDTH-1:0] i_command_write_mask,
  output logic             o_response_valid,
  input  logic             i_response_ready,
  output rggen_status      o_response_status,
  output logic [WIDTH-1:0] o_read_data,
  input  logic [WIDTH-1:0] i_hw_event,
  input  logic             i_hw_control,
  input  logic [WIDTH-1:0] i_hw_value,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] next_value;
  logic [WIDTH-1:0] field_value;
  logic             response_valid_q;
  rggen_status      status_q;
  logic [WIDTH-1:0] read_data_q;
  logic             accept;
  logic             write_accept;

  assign o_command_ready = !response_valid_q;
  assign accept          = i_command_valid && o_command_ready;
  assign write_accept    = accept && (i_command_direction == RGGEN_WRITE);
  assign field_value     = (MODE == RGGEN_FIELD_RO) ? i_hw_value : value_q;

  rggen_bit_field_next_value #(
    .WIDTH     (WIDTH),
    .MODE      (MODE),
    .RWSC_MODE (RWSC_MODE),
    .RWLE_MODE (RWLE_MODE)
  ) u_next_value (
    .value      (value_q),
    .write      (write_accept),
    .write_data (i_command_write_data),
    .write_mask (i_command_write_mask),
    .hw_event   (i_hw_event),
    .hw_control (i_hw_control),
    .next_value (next_value)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for flops so every always_ff samples pre-edge values.
    if (rst) value_q <= INITIAL_VALUE;
    else     value_q <= next_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      response_valid_q <= 1'b0;
      status_q         <= RGGEN_OKAY;
      read_data_q      <= '0;
    end else if (accept) begin
      response_valid_q <= 1'b1;
      status_q         <= (write_accept && (MODE == RGGEN_FIELD_RO)) ? RGGEN_SLAVE_ERROR
                                                                     : RGGEN_OKAY;
      read_data_q      <= write_accept ? '0 : field_value;
    end else if (response_valid_q && i_response_ready) begin
      response_valid_q <= 1'b0;
    end
  end

  assign o_response_valid  = response_valid_q;
  assign o_response_status = status_q;
  assign o_read_data       = read_data_q;
  assign o_value           = field_value;

endmodule

// File: tb/tb_rggen_bit_field_cell.sv
// Directed bench: five 8-bit cells (RW, RO, W1C, RWLE lock, RWSC set) share
// one command bus; each instance has its own command-valid line.
module tb_rggen_bit_field_cell;
  import rggen_bit_field_cell_pkg::*;

  localparam int W      = 8;
  localparam int N      = 5;
  localparam int I_RW   = 0;
  localparam int I_RO   = 1;
  localparam int I_W1C  = 2;
  localparam int I_RWLE = 3;
  localparam int I_RWSC = 4;

  function automatic rggen_field_mode mode_of(int i);
    case (i)
      0:       return RGGEN_FIELD_RW;
      1:       return RGGEN_FIELD_RO;
      2:       return RGGEN_FIELD_W1C;
      3:       return RGGEN_FIELD_RWLE;
      default: return RGGEN_FIELD_RWSC;
    endcase
  endfunction

  function automatic logic [W-1:0] init_of(int i);
    return (i == 0) ? 8'h5A : 8'h00;
  endfunction

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   cmd_valid;
  logic [N-1:0]   cmd_ready;
  logic [N-1:0]   rsp_valid;
  rggen_direction dir;
  logic [W-1:0]   wdata, wmask, hw_event, hw_value;
  logic           rsp_ready, hw_control;
  rggen_status    rsp_status [N];
  logic [W-1:0]   rdata [N];
  logic [W-1:0]   value [N];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rggen_bit_field_cell #(
      .WIDTH         (W),
      .INITIAL_VALUE (init_of(g)),
      .MODE          (mode_of(g)),
      .RWSC_MODE     (RGGEN_SET_MODE),
      .RWLE_MODE     (RGGEN_LOCK_MODE)
    ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .i_command_valid      (cmd_valid[g]),
      .o_command_ready      (cmd_ready[g]),
      .i_command_direction  (dir),
      .i_command_write_data (wdata),
      .i_command_write_mask (wmask),
      .o_response_valid     (rsp_valid[g]),
      .i_response_ready     (rsp_ready),
      .o_response_status    (rsp_status[g]),
      .o_read_data          (rdata[g]),
      .i_hw_event           (hw_event),
      .i_hw_control         (hw_control),
      .i_hw_value           (hw_value),
      .o_value              (value[g])
    );
  end

  task automatic idle_inputs();
    cmd_valid  = '0;
    dir        = RGGEN_READ;
    wdata      = '0;
    wmask      = '0;
    hw_event   = '0;
    hw_control = 1'b0;
    rsp_ready  = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One accepted access with response consumed immediately; ev is driven in the accept cycle.
  task automatic access(input int idx, input rggen_direction d, input logic [W-1:0] data,
                        input logic [W-1:0] mask, input logic [W-1:0] ev,
                        output rggen_status st, output logic [W-1:0] rd);
    int waited = 0;
    @(negedge clk);
    while (!cmd_ready[idx] && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (cmd_ready[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL access_ready[%0d]: got %b want 1", idx, cmd_ready[idx]);
    end
    cmd_valid[idx] = 1'b1;
    dir = d; wdata = data; wmask = mask; hw_event = ev;
    @(negedge clk);
    cmd_valid[idx] = 1'b0;
    wmask = '0; hw_event = '0;
    n_tests++;
    if (rsp_valid[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL access_latency[%0d]: response_valid got %b want 1", idx, rsp_valid[idx]);
    end
    st = rsp_status[idx];
    rd = rdata[idx];
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (rsp_valid[i] !== 1'b0 || cmd_ready[i] !== 1'b1 ||
          rsp_status[i] !== RGGEN_OKAY || rdata[i] !== 8'h00 || value[i] !== init_of(i)) begin
        n_fail++;
        $display("FAIL reset[%0d]: valid=%b ready=%b status=%0d rdata=%h value=%h want 0 1 0 00 %h",
                 i, rsp_valid[i], cmd_ready[i], rsp_status[i], rdata[i], value[i], init_of(i));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rw();
    rggen_status st;
    logic [W-1:0] rd;
    apply_reset();
    access(I_RW, RGGEN_WRITE, 8'hFF, 8'h0F, 8'h00, st, rd);
    n_tests++;
    if (st !== RGGEN_OKAY || value[I_RW] !== 8'h5F) begin
      n_fail++;
      $display("FAIL rw_write: status=%0d value=%h want 0 5f", st, value[I_RW]);
    end
    access(I_RW, RGGEN_READ, 8'h00, 8'h00, 8'h00, st, rd);
    n_tests++;
    if (st !== RGGEN_OKAY || rd !== 8'h5F) begin
      n_fail++;
      $display("FAIL rw_read: status=%0d rdata=%h want 0 5f", st, rd);
    end
    access(I_RW, RGGEN_WRITE, 8'h00, 8'h00, 8'h00, st, rd);
    n_tests++;
    if (st !== RGGEN_OKAY || value[I_RW] !== 8'h5F) begin
      n_fail++;
      $display("FAIL rw_mask_zero: status=%0d value=%h want 0 5f", st, value[I_RW]);
    end
  endtask

  task automatic test_ro();
    rggen_status st;
    logic [W-1:0] rd;
    hw_value = 8'h77;
    apply_reset();
    access(I_RO, RGGEN_WRITE, 8'h12, 8'hFF, 8'h00, st, rd);
    n_tests++;
    if (st !== RGGEN_SLAVE_ERROR || value[I_RO] !== 8'h77) begin
      n_fail++;
      $display("FAIL ro_write: status=%0d value=%h want 2 77", st, value[I_RO]);
    end
    hw_value = 8'h34;
    access(I_RO, RGGEN_READ, 8'h00, 8'h00, 8'h00, st, rd);
    n_tests++;
    if (st !== RGGEN_OKAY || rd !== 8'h34 || value[I_RO] !== 8'h34) begin
      n_fail++;
      $display("FAIL ro_read: status=%0d rdata=%h value=%h want 0 34 34", st, rd, value[I_RO]);
    end
  endtask

  task automatic test_w1c();
    rggen_status st;
    logic [W-1:0] rd;
    apply_reset();
    @(negedge clk);
    hw_event = 8'h81;
    @(negedge clk);
    hw_event = 8'h00;
    n_tests++;
    if (value[I_W1C] !== 8'h81) begin
      n_fail++;
      $display("FAIL w1c_hw_set: value=%h want 81", value[I_W1C]);
    end
    access(I_W1C, RGGEN_WRITE, 8'h01, 8'hFF, 8'h01, st, rd);
    n_tests++;
    if (st !== RGGEN_OKAY || value[I_W1C] !== 8'h81) begin
      n_fail++;
      $display("FAIL w1c_collision: status=%0d value=%h want 0 81", st, value[I_W1C]);
    end
    access(I_W1C, RGGEN_WRITE, 8'h80, 8'hFF, 8'h00, st, rd);
    n_tests++;
    if (value[I_W1C] !== 8'h01) begin
      n_fail++;
      $display("FAIL w1c_clear: value=%h want 01", value[I_W1C]);
    end
  endtask

  task automatic test_rwle();
    rggen_status st;
    logic [W-1:0] rd;
    apply_reset();
    hw_control = 1'b1;
    access(I_RWLE, RGGEN_WRITE, 8'hAA, 8'hFF, 8'h00, st, rd);
    n_tests++;
    if (st !== RGGEN_OKAY || value[I_RWLE] !== 8'h00) begin
      n_fail++;
      $display("FAIL rwle_locked: status=%0d value=%h want 0 00", st, value[I_RWLE]);
    end
    hw_control = 1'b0;
    access(I_RWLE, RGGEN_WRITE, 8'hAA, 8'hFF, 8'h00, st, rd);
    n_tests++;
    if (st !== RGGEN_OKAY || value[I_RWLE] !== 8'hAA) begin
      n_fail++;
      $display("FAIL rwle_unlocked: status=%0d value=%h want 0 aa", st, value[I_RWLE]);
    end
  endtask

  task automatic test_rwsc();
    rggen_status st;
    logic [W-1:0] rd;
    apply_reset();
    access(I_RWSC, RGGEN_WRITE, 8'h0F, 8'hFF, 8'h00, st, rd);
    n_tests++;
    if (value[I_RWSC] !== 8'h0F) begin
      n_fail++;
      $display("FAIL rwsc_write: value=%h want 0f", value[I_RWSC]);
    end
    access(I_RWSC, RGGEN_WRITE, 8'h00, 8'hFF, 8'hF0, st, rd);
    n_tests++;
    if (value[I_RWSC] !== 8'hF0) begin
      n_fail++;
      $display("FAIL rwsc_collision: value=%h want f0", value[I_RWSC]);
    end
    @(negedge clk);
    hw_event = 8'h01;
    @(negedge clk);
    hw_event = 8'h00;
    n_tests++;
    if (value[I_RWSC] !== 8'hF1) begin
      n_fail++;
      $display("FAIL rwsc_idle_event: value=%h want f1", value[I_RWSC]);
    end
  endtask

  task automatic test_handshake();
    apply_reset();
    @(negedge clk);
    cmd_valid[I_RW] = 1'b1;
    dir = RGGEN_READ;
    rsp_ready = 1'b0;
    @(negedge clk);
    // A write held on the bus while the response stalls must not be taken.
    dir = RGGEN_WRITE; wdata = 8'h00; wmask = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (rsp_valid[I_RW] !== 1'b1 || rsp_status[I_RW] !== RGGEN_OKAY ||
          rdata[I_RW] !== 8'h5A || cmd_ready[I_RW] !== 1'b0 || value[I_RW] !== 8'h5A) begin
        n_fail++;
        $display("FAIL stall[%0d]: valid=%b status=%0d rdata=%h ready=%b value=%h want 1 0 5a 0 5a",
                 c, rsp_valid[I_RW], rsp_status[I_RW], rdata[I_RW], cmd_ready[I_RW], value[I_RW]);
      end
      @(negedge clk);
    end
    cmd_valid[I_RW] = 1'b0;
    wmask = 8'h00;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rsp_valid[I_RW] !== 1'b0 || cmd_ready[I_RW] !== 1'b1 || value[I_RW] !== 8'h5A) begin
      n_fail++;
      $display("FAIL release: valid=%b ready=%b value=%h want 0 1 5a",
               rsp_valid[I_RW], cmd_ready[I_RW], value[I_RW]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    cmd_valid[I_RW] = 1'b1;
    dir = RGGEN_WRITE; wdata = 8'h11; wmask = 8'hFF;
    @(negedge clk);
    wdata = 8'h22;
    n_tests++;
    if (rsp_valid[I_RW] !== 1'b1 || value[I_RW] !== 8'h11) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b value=%h want 1 11", rsp_valid[I_RW], value[I_RW]);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid[I_RW] !== 1'b0 || cmd_ready[I_RW] !== 1'b1 || value[I_RW] !== 8'h11) begin
      n_fail++;
      $display("FAIL b2b_gap: valid=%b ready=%b value=%h want 0 1 11",
               rsp_valid[I_RW], cmd_ready[I_RW], value[I_RW]);
    end
    @(negedge clk);
    cmd_valid[I_RW] = 1'b0;
    wmask = 8'h00;
    n_tests++;
    if (rsp_valid[I_RW] !== 1'b1 || value[I_RW] !== 8'h22) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b value=%h want 1 22", rsp_valid[I_RW], value[I_RW]);
    end
  endtask

  task automatic test_reset_pending();
    apply_reset();
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid[I_RW] = 1'b1;
    dir = RGGEN_WRITE; wdata = 8'h00; wmask = 8'hFF;
    @(negedge clk);
    cmd_valid[I_RW] = 1'b0;
    wmask = 8'h00;
    n_tests++;
    if (rsp_valid[I_RW] !== 1'b1 || value[I_RW] !== 8'h00) begin
      n_fail++;
      $display("FAIL pending_setup: valid=%b value=%h want 1 00", rsp_valid[I_RW], value[I_RW]);
    end
    rst = 1'b1;
    hw_event = 8'hFF;
    @(negedge clk);
    n_tests++;
    if (rsp_valid[I_RW] !== 1'b0 || cmd_ready[I_RW] !== 1'b1 || value[I_RW] !== 8'h5A ||
        value[I_W1C] !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_pending: valid=%b ready=%b value=%h w1c=%h want 0 1 5a 00",
               rsp_valid[I_RW], cmd_ready[I_RW], value[I_RW], value[I_W1C]);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    hw_value = 8'h00;
    idle_inputs();
    test_reset();
    test_rw();
    test_ro();
    test_w1c();
    test_rwle();
    test_rwsc();
    test_handshake();
    test_back_to_back();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
